// File: rtl/reorder_buffer_wide.sv
// Dual-dispatch, dual-retire reorder buffer with CDB result capture,
// operand lookup with same-cycle bypass, and branch-mispredict squash.
module reorder_buffer_wide #(
    parameter  int DEPTH      = 8,
    parameter  int DATA_WIDTH = 16,
    parameter  int REG_W      = 5,
    parameter  int NCDB       = 2,
    localparam int TAG_W      = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 disp_valid,
    input  logic [3:0]                 disp_type,
    input  logic [2*REG_W-1:0]         disp_dest,
    output logic                       disp_ready,
    output logic [2*TAG_W-1:0]         disp_tag,
    input  logic [NCDB-1:0]            cdb_valid,
    input  logic [NCDB*TAG_W-1:0]      cdb_tag,
    input  logic [NCDB*DATA_WIDTH-1:0] cdb_data,
    input  logic [4*TAG_W-1:0]         src_tag,
    output logic [3:0]                 src_ready,
    output logic [4*DATA_WIDTH-1:0]    src_data,
    input  logic                       br_valid,
    input  logic [TAG_W-1:0]           br_tag,
    input  logic                       br_mispredict,
    output logic [1:0]                 cmt_valid,
    output logic [3:0]                 cmt_type,
    output logic [2*REG_W-1:0]         cmt_dest,
    output logic [2*DATA_WIDTH-1:0]    cmt_data,
    output logic [TAG_W:0]             count,
    output logic                       empty
);

    typedef enum logic [1:0] {
        T_REG    = 2'b00,
        T_STORE  = 2'b01,
        T_BRANCH = 2'b10,
        T_NODEST = 2'b11
    } rob_type_e;

    typedef logic [TAG_W:0] ptr_t;

    rob_type_e             ent_type [DEPTH];
    logic [REG_W-1:0]      ent_dest [DEPTH];
    logic [DATA_WIDTH-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      done;

    ptr_t             head, tail, occ;
    logic [TAG_W-1:0] head_idx, head_nxt_idx, tail_idx, tail_nxt_idx;

    logic             br_hit, squash;
    logic [TAG_W-1:0] br_off;
    logic [1:0]       ret;
    ptr_t             n_ret, n_alloc;

    logic             do_alloc, alloc_a, alloc_b;
    rob_type_e        a_type, b_type;
    logic [REG_W-1:0] a_dest, b_dest;

    logic [DEPTH-1:0]      cdb_match;
    logic [DEPTH-1:0]      cdb_wr;
    logic [DEPTH-1:0]      younger;
    logic [DATA_WIDTH-1:0] cdb_val [DEPTH];

    assign head_idx     = head[TAG_W-1:0];
    assign tail_idx     = tail[TAG_W-1:0];
    assign head_nxt_idx = head_idx + TAG_W'(1);
    assign tail_nxt_idx = tail_idx + TAG_W'(1);

    // Pointer difference gives occupancy; the extra wrap bit separates full from empty.
    assign occ        = tail - head;
    assign count      = occ;
    assign empty      = (occ == '0);
    assign disp_ready = (occ <= ptr_t'(DEPTH - 2));
    assign disp_tag   = {tail_nxt_idx, tail_idx};

    assign br_hit = br_valid && busy[br_tag];
    assign squash = br_hit && br_mispredict;
    assign br_off = br_tag - head_idx;

    // A younger entry sitting at head+1 must not retire while it is being squashed.
    assign ret[0]    = busy[head_idx] & done[head_idx];
    assign ret[1]    = ret[0] & busy[head_nxt_idx] & done[head_nxt_idx]
                       & ~(squash && (br_off == '0));
    assign n_ret     = ptr_t'(ret[0]) + ptr_t'(ret[1]);
    assign cmt_valid = ret;
    assign cmt_type  = {ent_type[head_nxt_idx], ent_type[head_idx]};
    assign cmt_dest  = {ent_dest[head_nxt_idx], ent_dest[head_idx]};
    assign cmt_data  = {ent_data[head_nxt_idx], ent_data[head_idx]};

    // Packed allocation: the first valid slot always lands on tail.
    always_comb begin
        do_alloc = disp_ready && !squash;
        alloc_a  = do_alloc && (disp_valid != 2'b00);
        alloc_b  = do_alloc && (disp_valid == 2'b11);
        if (disp_valid[0]) begin
            a_type = rob_type_e'(disp_type[1:0]);
            a_dest = disp_dest[REG_W-1:0];
        end else begin
            a_type = rob_type_e'(disp_type[3:2]);
            a_dest = disp_dest[2*REG_W-1:REG_W];
        end
        b_type  = rob_type_e'(disp_type[3:2]);
        b_dest  = disp_dest[2*REG_W-1:REG_W];
        n_alloc = ptr_t'(alloc_a) + ptr_t'(alloc_b);
    end

    // Per-entry CDB match (lowest port wins), squash age test and write enable.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cdb_match[i] = 1'b0;
            cdb_val[i]   = '0;
            for (int unsigned p = 0; p < NCDB; p++) begin
                if (!cdb_match[i] && cdb_valid[p] &&
                    (cdb_tag[p*TAG_W +: TAG_W] == TAG_W'(i))) begin
                    cdb_match[i] = 1'b1;
                    cdb_val[i]   = cdb_data[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            younger[i] = busy[i] && ((TAG_W'(i) - head_idx) > br_off);
            cdb_wr[i]  = cdb_match[i] && busy[i] && !done[i]
                         && (ent_type[i] == T_REG || ent_type[i] == T_STORE)
                         && !(squash && younger[i]);
        end
    end

    // Operand lookup: stored result first, otherwise same-cycle CDB bypass.
    always_comb begin
        src_ready = '0;
        src_data  = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (busy[src_tag[k*TAG_W +: TAG_W]] && done[src_tag[k*TAG_W +: TAG_W]]) begin
                src_ready[k]                         = 1'b1;
                src_data[k*DATA_WIDTH +: DATA_WIDTH] = ent_data[src_tag[k*TAG_W +: TAG_W]];
            end else if (busy[src_tag[k*TAG_W +: TAG_W]] && cdb_match[src_tag[k*TAG_W +: TAG_W]]) begin
                src_ready[k]                         = 1'b1;
                src_data[k*DATA_WIDTH +: DATA_WIDTH] = cdb_val[src_tag[k*TAG_W +: TAG_W]];
            end
        end
    end

    // Pointer and entry state update: completion, squash, retire, allocate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            busy <= '0;
            done <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_type[i] <= T_NODEST;
                ent_dest[i] <= '0;
                ent_data[i] <= '0;
            end
        end else begin
            head <= head + n_ret;
            // head + offset-of-branch + 1 carries the correct wrap bit into tail.
            tail <= squash ? (head + ptr_t'(br_off) + ptr_t'(1)) : (tail + n_alloc);
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (cdb_wr[i]) begin
                    done[i]     <= 1'b1;
                    ent_data[i] <= cdb_val[i];
                end
                if (br_hit && (br_tag == TAG_W'(i)) && (ent_type[i] == T_BRANCH))
                    done[i] <= 1'b1;
                if (squash && younger[i]) begin
                    busy[i] <= 1'b0;
                    done[i] <= 1'b0;
                end
            end
            if (ret[0]) begin
                busy[head_idx] <= 1'b0;
                done[head_idx] <= 1'b0;
            end
            if (ret[1]) begin
                busy[head_nxt_idx] <= 1'b0;
                done[head_nxt_idx] <= 1'b0;
            end
            if (alloc_a) begin
                busy[tail_idx]     <= 1'b1;
                done[tail_idx]     <= (a_type == T_NODEST);
                ent_type[tail_idx] <= a_type;
                ent_dest[tail_idx] <= a_dest;
            end
            if (alloc_b) begin
                busy[tail_nxt_idx]     <= 1'b1;
                done[tail_nxt_idx]     <= (b_type == T_NODEST);
                ent_type[tail_nxt_idx] <= b_type;
                ent_dest[tail_nxt_idx] <= b_dest;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer_wide.sv
// Directed bench for reorder_buffer_wide with an in-order commit scoreboard.
module tb_reorder_buffer_wide;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  disp_valid;
    logic [3:0]  disp_type;
    logic [9:0]  disp_dest;
    logic        disp_ready;
    logic [5:0]  disp_tag;
    logic [1:0]  cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [11:0] src_tag;
    logic [3:0]  src_ready;
    logic [63:0] src_data;
    logic        br_valid;
    logic [2:0]  br_tag;
    logic        br_mispredict;
    logic [1:0]  cmt_valid;
    logic [3:0]  cmt_type;
    logic [9:0]  cmt_dest;
    logic [31:0] cmt_data;
    logic [3:0]  count;
    logic        empty;

    typedef struct packed {
        logic [1:0]  typ;
        logic [4:0]  dest;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    reorder_buffer_wide #(
        .DEPTH(8), .DATA_WIDTH(16), .REG_W(5), .NCDB(2)
    ) dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_type(disp_type), .disp_dest(disp_dest),
        .disp_ready(disp_ready), .disp_tag(disp_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .src_tag(src_tag), .src_ready(src_ready), .src_data(src_data),
        .br_valid(br_valid), .br_tag(br_tag), .br_mispredict(br_mispredict),
        .cmt_valid(cmt_valid), .cmt_type(cmt_type), .cmt_dest(cmt_dest),
        .cmt_data(cmt_data), .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        disp_valid = '0; disp_type = '0; disp_dest = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
        src_tag = '0; br_valid = 1'b0; br_tag = '0; br_mispredict = 1'b0;
    endtask

    task automatic disp(input logic [1:0] v, input logic [1:0] t0, input logic [1:0] t1,
                        input logic [4:0] d0, input logic [4:0] d1,
                        input logic [15:0] e0, input logic [15:0] e1, input logic [1:0] push);
        disp_valid = v;
        disp_type  = {t1, t0};
        disp_dest  = {d1, d0};
        if (push[0]) sb.push_back({t0, d0, e0});
        if (push[1]) sb.push_back({t1, d1, e1});
    endtask

    task automatic cdb(input logic [1:0] v, input logic [2:0] t0, input logic [2:0] t1,
                       input logic [15:0] x0, input logic [15:0] x1);
        cdb_valid = v;
        cdb_tag   = {t1, t0};
        cdb_data  = {x1, x0};
    endtask

    // One clock: compare any retirements against the scoreboard, then step.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (cmt_valid[k]) begin
                if (sb.size() == 0) begin
                    check("commit_unexpected", 64'(cmt_valid[k]), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("commit_type", 64'(cmt_type[2*k +: 2]), 64'(e.typ));
                    check("commit_dest", 64'(cmt_dest[5*k +: 5]), 64'(e.dest));
                    if (e.typ == 2'b00)
                        check("commit_data", 64'(cmt_data[16*k +: 16]), 64'(e.data));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget, input string tag);
        for (int i = 0; i < budget && sb.size() > 0; i++) cycle();
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        idle();
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        src_tag = 12'h002;
        #1;
        check("reset_count", 64'(count), 64'd0);
        check("reset_empty", 64'(empty), 64'd1);
        check("reset_ready", 64'(disp_ready), 64'd1);
        check("reset_cmt", 64'(cmt_valid), 64'd0);
        check("reset_src", 64'(src_ready), 64'd0);
        idle();
        rst = 1'b1;
        cycle();

        // Two reg writes completing out of order, retiring together.
        disp(2'b11, 2'b00, 2'b00, 5'd3, 5'd4, 16'h0011, 16'h0022, 2'b11);
        #1 check("t1_disp_tag", 64'(disp_tag), 64'b001_000);
        cycle();
        idle();
        #1 check("t1_count", 64'(count), 64'd2);
        cdb(2'b01, 3'd1, 3'd0, 16'h0022, 16'h0);
        cycle();
        cdb(2'b01, 3'd0, 3'd0, 16'h0011, 16'h0);
        cycle();
        idle();
        #1 check("t1_dual_commit", 64'(cmt_valid), 64'b11);
        cycle();
        check("t1_empty_after", 64'(count), 64'd0);
        check("t1_sb", 64'(sb.size()), 64'd0);

        // Fill to full from a fresh reset, then retire two with dispatch blocked.
        rst = 1'b0; sb.delete(); cycle(); rst = 1'b1; cycle();
        for (int p = 0; p < 4; p++) begin
            #1 check("t2_ready_fill", 64'(disp_ready), 64'd1);
            disp(2'b11, 2'b00, 2'b00, 5'(8 + 2*p), 5'(9 + 2*p),
                 16'(16'h200 + 2*p), 16'(16'h201 + 2*p), 2'b11);
            cycle();
        end
        idle();
        #1;
        check("t2_full_count", 64'(count), 64'd8);
        check("t2_full_ready", 64'(disp_ready), 64'd0);
        cdb(2'b11, 3'd0, 3'd1, 16'h0200, 16'h0201);
        cycle();
        idle();
        disp(2'b11, 2'b00, 2'b00, 5'd20, 5'd21, 16'h0, 16'h0, 2'b00);
        #1;
        check("t2_retire_cmt", 64'(cmt_valid), 64'b11);
        check("t2_ready_start_of_cycle", 64'(disp_ready), 64'd0);
        cycle();
        idle();
        #1;
        check("t2_count_after", 64'(count), 64'd6);
        check("t2_ready_after", 64'(disp_ready), 64'd1);
        check("t2_wrap_tag", 64'(disp_tag), 64'b001_000);
        cdb(2'b01, 3'd2, 3'd0, 16'h0202, 16'h0);
        cycle();
        idle();
        #1 check("t2_pre_reset_cmt", 64'(cmt_valid), 64'b01);
        rst = 1'b0;
        #1;
        check("t2_rst_count", 64'(count), 64'd0);
        check("t2_rst_empty", 64'(empty), 64'd1);
        check("t2_rst_cmt", 64'(cmt_valid), 64'd0);
        check("t2_rst_ready", 64'(disp_ready), 64'd1);
        sb.delete();
        cycle(); cycle();
        rst = 1'b1;
        cycle();

        // Mispredicted branch at tag 2 squashes tags 3..5.
        disp(2'b11, 2'b00, 2'b00, 5'd1, 5'd2, 16'h0100, 16'h0101, 2'b11); cycle();
        disp(2'b11, 2'b10, 2'b00, 5'd0, 5'd5, 16'h0, 16'h0555, 2'b01);    cycle();
        disp(2'b11, 2'b00, 2'b00, 5'd6, 5'd7, 16'h0, 16'h0, 2'b00);       cycle();
        idle();
        #1 check("t3_count_pre", 64'(count), 64'd6);
        br_valid = 1'b1; br_tag = 3'd2; br_mispredict = 1'b1;
        disp(2'b11, 2'b11, 2'b11, 5'd10, 5'd11, 16'h0, 16'h0, 2'b00);
        cdb(2'b01, 3'd4, 3'd0, 16'h0099, 16'h0);
        cycle();
        idle();
        #1;
        check("t3_squash_count", 64'(count), 64'd3);
        check("t3_squash_tail", 64'(disp_tag[2:0]), 64'd3);
        cdb(2'b01, 3'd4, 3'd0, 16'h0077, 16'h0);
        src_tag[2:0] = 3'd4;
        #1;
        check("t3_late_src_ready", 64'(src_ready[0]), 64'd0);
        check("t3_late_src_data", 64'(src_data[15:0]), 64'd0);
        cycle();
        idle();
        #1 check("t3_late_count", 64'(count), 64'd3);
        disp(2'b10, 2'b00, 2'b11, 5'd0, 5'd9, 16'h0, 16'h0, 2'b10);
        #1 check("t3_next_tag", 64'(disp_tag[2:0]), 64'd3);
        cycle();
        idle();
        #1 check("t3_count_slot1", 64'(count), 64'd4);
        cdb(2'b11, 3'd0, 3'd1, 16'h0100, 16'h0101);
        cycle();
        idle();
        src_tag[2:0] = 3'd0;
        #1;
        check("t3_src_stored_rdy", 64'(src_ready[0]), 64'd1);
        check("t3_src_stored_data", 64'(src_data[15:0]), 64'h0100);
        drain(8, "t3_drain");
        check("t3_final_count", 64'(count), 64'd0);
        check("t3_final_empty", 64'(empty), 64'd1);

        // Dual CDB hit on one tag, bypass lookup, and blocked head.
        disp(2'b11, 2'b00, 2'b00, 5'd6, 5'd7, 16'h0044, 16'h00AA, 2'b11);
        #1 check("t4_disp_tag", 64'(disp_tag), 64'b101_100);
        cycle();
        idle();
        cdb(2'b11, 3'd5, 3'd5, 16'h00AA, 16'h00BB);
        src_tag[2:0] = 3'd5;
        #1;
        check("t4_bypass_rdy", 64'(src_ready[0]), 64'd1);
        check("t4_bypass_data", 64'(src_data[15:0]), 64'h00AA);
        cycle();
        idle();
        src_tag[5:3] = 3'd5;
        #1;
        check("t4_head_not_done", 64'(cmt_valid), 64'b00);
        check("t4_stored_rdy", 64'(src_ready[1]), 64'd1);
        check("t4_stored_data", 64'(src_data[31:16]), 64'h00AA);
        cdb(2'b10, 3'd0, 3'd4, 16'h0, 16'h0044);
        cycle();
        idle();
        #1 check("t4_dual_commit", 64'(cmt_valid), 64'b11);
        drain(4, "t4_drain");

        // Branch resolution to an unallocated tag changes nothing.
        br_valid = 1'b1; br_tag = 3'd2; br_mispredict = 1'b1;
        cycle();
        idle();
        #1;
        check("t5_count", 64'(count), 64'd0);
        check("t5_tail", 64'(disp_tag[2:0]), 64'd6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reorder_buffer_wide.md
REORDER_BUFFER_WIDE -- requirements
Module: reorder_buffer_wide

Interface
REQ-001 SHALL have parameter DEPTH, 8: entries; power of two, >= 4.
REQ-002 SHALL have parameter DATA_WIDTH, 16: result data width.
REQ-003 SHALL have parameter REG_W, 5: architectural destination register address width.
REQ-004 SHALL have parameter NCDB, 2: number of CDB broadcast ports.
REQ-005 SHALL derive TAG_W = log2(DEPTH) internally.
REQ-006 SHALL run on one clock and use an asynchronous, active-low reset.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  asynchronous active-low reset.
REQ-009 disp_valid  in  2  dispatch slot valid; slot0 is older.
REQ-010 disp_type  in  2x2  per slot: 00 reg write, 01 store, 10 branch, 11 no destination.
REQ-011 disp_dest  in  2xREG_W  per-slot destination register.
REQ-012 disp_ready  out  1  at least 2 free entries.
REQ-013 disp_tag  out  2xTAG_W  tags that slots 0 and 1 will receive.
REQ-014 cdb_valid / cdb_tag / cdb_data  in  NCDB / NCDBxTAG_W / NCDBxDATA_WIDTH  result broadcasts.
REQ-015 src_tag  in  4xTAG_W  operand lookup tags.
REQ-016 src_ready / src_data  out  4 / 4xDATA_WIDTH  lookup hit and value.
REQ-017 br_valid / br_tag / br_mispredict  in  1 / TAG_W / 1  branch resolution.
REQ-018 cmt_valid / cmt_type / cmt_dest / cmt_data  out  2 / 2x2 / 2xREG_W / 2xDATA_WIDTH  retire ports.
REQ-019 count  out  TAG_W+1  occupied entries; empty  out  1  count==0.

Function
REQ-020 SHALL be a circular buffer with head/tail pointers of TAG_W+1 bits; full when the low bits are equal and the wrap bits differ.
REQ-021 SHALL set disp_tag slot0=tail and slot1=tail+1 (mod DEPTH), combinationally.
REQ-022 SHALL allocate at posedge when disp_ready and disp_valid are set; allocation is packed: slot1 alone takes tail, both take tail and tail+1.
REQ-023 SHALL compute disp_ready from start-of-cycle occupancy; same-cycle retirements do not free space for that cycle's dispatch.
REQ-024 SHALL mark type 11 entries done at allocation.
REQ-025 SHALL mark type 00/01 entries done and latch data on a matching CDB tag; if multiple ports match, the lowest port index wins.
REQ-026 SHALL ignore CDB writes to unallocated entries.
REQ-027 SHALL mark branch entries done only on br_valid with a matching br_tag.
REQ-028 src_ready SHALL be 1 with stored data if the entry is allocated and done; else 1 with bypassed data on a same-cycle CDB match; else 0 with data 0.
REQ-029 SHALL drive cmt_valid[0] combinationally when the head entry is done, and cmt_valid[1] when cmt_valid[0] and head+1 are both done; retirement is strictly in order.
REQ-030 SHALL advance head by the number of retired entries at posedge, clearing their busy bits.
REQ-031 On br_valid with br_mispredict, SHALL squash at posedge every entry younger than br_tag: tail becomes br_tag+1 with the correct wrap bit, and same-cycle dispatch is dropped.
REQ-032 SHALL allow retirement in a mispredict cycle for entries at or older than br_tag.
REQ-033 SHALL ignore CDB writes to squashed entries in the squash cycle.
REQ-034 SHALL ignore br_valid to an unallocated tag.
REQ-035 SHALL update count as count + allocated - retired - squashed each cycle.

Reset
REQ-036 On rst low, SHALL asynchronously clear head, tail, all busy/done bits and count.
REQ-037 During and after reset, SHALL hold cmt_valid=0, src_ready=0, empty=1 and disp_ready=1.
REQ-038 Reset mid-operation SHALL discard all entries with no retirement.

Verification (DEPTH=8, NCDB=2)
REQ-039 Reset release, then dispatch 2 reg-writes (dest 3, 4) -> disp_tag 0/1, count=2; CDB tag1 = 0x22 then tag0 = 0x11 -> both retire in the same cycle: dest 3 = 0x11, dest 4 = 0x22.
REQ-040 Dispatch 8 entries -> disp_ready=0 at count=8; retire 2 with dispatch held -> disp_ready=1 the next cycle and tags wrap to 0/1.
REQ-041 Branch at tag 2, younger entries 3-5, mispredict -> tail=3, count=3; late CDB to tag 4 is ignored; next dispatch receives tag 3.
REQ-042 Both CDB ports carry tag 5 (0xAA on port0, 0xBB on port1) -> entry 5 = 0xAA; src_tag=5 in that cycle -> src_ready=1, data 0xAA.
REQ-043 Head not done while head+1 is done -> cmt_valid = 00.
REQ-044 rst asserted with 6 entries live -> count=0 and empty=1 immediately, with no commit pulse.
